// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised pipeline stage register. Carries a data payload and a control
//   bundle across one stage boundary with a valid/ready handshake, optional
//   2-entry skid buffer and synchronous flush. The control bundle is zero
//   whenever the output slot holds a bubble, so a stalled or flushed slot can
//   never assert write/branch controls downstream.
//
// Handshake: an entry moves on a port only in a cycle where valid and ready
//   are both high at the rising clock edge (in_fire / out_fire). The producer
//   must hold valid and payload stable until the entry is taken; valid never
//   depends combinationally on ready.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous kill of all held entries (highest priority)
//   in_valid/ready  upstream handshake
//   in_data/ctrl    upstream payload and control bundle
//   out_valid/ready downstream handshake (out_ready=0 stalls)
//   out_data/ctrl   registered payload/control; out_ctrl is 0 on a bubble
//   drop_cnt        saturating count of valid entries discarded by flush
//
// Parameters:
//   DATA_W   payload width
//   CTRL_W   control bundle width
//   SKID_EN  1: 2-entry skid, registered in_ready; 0: single entry,
//            combinational in_ready = !out_valid | out_ready
//   CNT_W    width of drop_cnt
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 16,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  drop_cnt
);

    // Number of entries held. TWO is only reachable with SKID_EN=1, because
    // without the skid an in_fire in ONE requires out_ready (hence out_fire).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                in_fire;
    logic                out_fire;
    logic [1:0]          held;
    logic [1:0]          drops;
    logic [CNT_W:0]      drop_sum;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign drop_cnt  = drop_cnt_q;

    always_comb begin
        if (SKID_EN != 0) begin
            in_ready = in_ready_q;
        end else begin
            in_ready = !out_valid | out_ready;
        end
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Entries held but not taken by downstream this cycle: these are the ones
    // a flush discards.
    always_comb begin
        held = 2'd0;
        case (state_q)
            ONE:     held = 2'd1;
            TWO:     held = 2'd2;
            default: held = 2'd0;
        endcase
        drops    = held - {1'b0, out_fire};
        drop_sum = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drops);
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    state_d     = TWO;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_fire) begin
                    // Drain to a bubble: data is kept, control is cleared.
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: begin
                state_d     = EMPTY;
                main_ctrl_d = '0;
            end
        endcase

        // Flush overrides everything above; an entry arriving in the same
        // cycle is discarded without being counted.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = '0;
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
            if (drop_sum[CNT_W]) begin
                drop_cnt_d = '1;
            end else begin
                drop_cnt_d = drop_sum[CNT_W-1:0];
            end
        end

        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Three instances share one input stream and one out_ready:
//     d0: SKID_EN=1, CNT_W=16   d1: SKID_EN=0, CNT_W=16   d2: SKID_EN=1, CNT_W=2
//   Each instance has its own reference model: an ordered list of held
//   entries with a capacity, a drop counter and the last shown payload.
//   Inputs change on the falling edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_ready;

    logic        d0_in_ready, d0_out_valid;
    logic [63:0] d0_out_data;
    logic [15:0] d0_out_ctrl;
    logic [15:0] d0_drop_cnt;
    logic        d1_in_ready, d1_out_valid;
    logic [63:0] d1_out_data;
    logic [15:0] d1_out_ctrl;
    logic [15:0] d1_drop_cnt;
    logic        d2_in_ready, d2_out_valid;
    logic [63:0] d2_out_data;
    logic [15:0] d2_out_ctrl;
    logic [1:0]  d2_drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    int          m_cnt  [3];
    logic [63:0] m_d    [3][2];
    logic [15:0] m_c    [3][2];
    logic [63:0] m_last [3];
    int          m_drop [3];
    bit          m_rdy  [3];
    bit          is_skid[3];
    int          sat_max[3];

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID_EN(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d0_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(d0_out_valid), .out_ready(out_ready), .out_data(d0_out_data),
        .out_ctrl(d0_out_ctrl), .drop_cnt(d0_drop_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID_EN(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d1_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(d1_out_valid), .out_ready(out_ready), .out_data(d1_out_data),
        .out_ctrl(d1_out_ctrl), .drop_cnt(d1_drop_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID_EN(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
        .out_ctrl(d2_out_ctrl), .drop_cnt(d2_drop_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 0;
            m_last[k] = '0;
            m_drop[k] = 0;
            m_rdy[k]  = 1'b1;
        end
    endtask

    function automatic bit model_ready(input int k);
        if (is_skid[k]) return m_rdy[k];
        return (m_cnt[k] == 0) || out_ready;
    endfunction

    task automatic check_dut(input int k);
        logic        ov, ordy;
        logic [63:0] od;
        logic [15:0] oc, odrop;
        ov = 1'b0; ordy = 1'b0; od = '0; oc = '0; odrop = '0;
        case (k)
            0: begin ov = d0_out_valid; ordy = d0_in_ready; od = d0_out_data;
                     oc = d0_out_ctrl; odrop = d0_drop_cnt; end
            1: begin ov = d1_out_valid; ordy = d1_in_ready; od = d1_out_data;
                     oc = d1_out_ctrl; odrop = d1_drop_cnt; end
            default: begin ov = d2_out_valid; ordy = d2_in_ready; od = d2_out_data;
                     oc = d2_out_ctrl; odrop = {14'b0, d2_drop_cnt}; end
        endcase
        check($sformatf("d%0d.out_valid", k), {63'b0, ov}, {63'b0, (m_cnt[k] > 0)});
        check($sformatf("d%0d.out_data", k), od, m_last[k]);
        check($sformatf("d%0d.out_ctrl", k), {48'b0, oc},
              {48'b0, (m_cnt[k] > 0) ? m_c[k][0] : 16'h0});
        check($sformatf("d%0d.in_ready", k), {63'b0, ordy}, {63'b0, model_ready(k)});
        check($sformatf("d%0d.drop_cnt", k), {48'b0, odrop}, 64'(m_drop[k]));
    endtask

    // Advance one instance's model across a clock edge using current inputs.
    task automatic model_update(input int k);
        bit rdy, inf, of;
        int dr;
        rdy = model_ready(k);
        inf = in_valid && rdy;
        of  = (m_cnt[k] > 0) && out_ready;
        if (flush) begin
            dr = m_cnt[k] - (of ? 1 : 0);
            m_drop[k] = (m_drop[k] + dr > sat_max[k]) ? sat_max[k] : m_drop[k] + dr;
            m_cnt[k]  = 0;
        end else begin
            if (of) begin
                m_d[k][0] = m_d[k][1];
                m_c[k][0] = m_c[k][1];
                m_cnt[k]--;
            end
            if (inf) begin
                m_d[k][m_cnt[k]] = in_data;
                m_c[k][m_cnt[k]] = in_ctrl;
                m_cnt[k]++;
            end
        end
        if (m_cnt[k] > 0) m_last[k] = m_d[k][0];
        m_rdy[k] = (m_cnt[k] < 2);
    endtask

    // Driver: one clock cycle. Called on a falling edge, returns on the next.
    task automatic step(input bit v, input logic [63:0] d, input logic [15:0] c,
                        input bit ordy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
        for (int k = 0; k < 3; k++) model_update(k);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 64'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse raised mid-cycle.
    task automatic pulse_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        is_skid = '{1'b1, 1'b0, 1'b1};
        sat_max = '{65535, 65535, 3};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        model_reset();

        // Reset values while held in reset.
        #2;
        for (int k = 0; k < 3; k++) check_dut(k);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Streaming 0x10..0x1F, ctrl 0x0001..0x0010, downstream always ready.
        for (int i = 0; i < 16; i++) step(1'b1, 64'(8'h10 + i), 16'(i + 1), 1'b1, 1'b0);
        step(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

        // Stall/skid: A, B, C offered while downstream stalls, then release.
        step(1'b1, 64'hA, 16'h00A1, 1'b0, 1'b0);
        step(1'b1, 64'hB, 16'h00B2, 1'b0, 1'b0);
        check("d0.stall_in_ready", {63'b0, d0_in_ready}, 64'h0);
        step(1'b1, 64'hC, 16'h00C3, 1'b0, 1'b0);
        step(1'b1, 64'hC, 16'h00C3, 1'b1, 1'b0);
        step(1'b1, 64'hC, 16'h00C3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

        // Flush with two held entries and a new entry D offered alongside.
        step(1'b1, 64'h21, 16'h0021, 1'b0, 1'b0);
        step(1'b1, 64'h22, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 64'hD, 16'h000D, 1'b0, 1'b1);
        idle();
        check("d0.drop_after_two", 64'(d0_drop_cnt), 64'd2);
        // Second flush with one held entry.
        step(1'b1, 64'h23, 16'h0023, 1'b0, 1'b0);
        step(1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
        idle();
        check("d0.drop_after_one", 64'(d0_drop_cnt), 64'd3);

        // Saturation: repeated flushes of a full buffer.
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 64'(16'h3000 + r), 16'h0301, 1'b0, 1'b0);
            step(1'b1, 64'(16'h3100 + r), 16'h0302, 1'b0, 1'b0);
            step(1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
        end
        idle();
        check("d2.drop_saturated", {62'b0, d2_drop_cnt}, 64'd3);

        // Flush while downstream takes the head: only the skid entry is a drop.
        step(1'b1, 64'h41, 16'h0041, 1'b0, 1'b0);
        step(1'b1, 64'h42, 16'h0042, 1'b0, 1'b0);
        step(1'b0, 64'h0, 16'h0, 1'b1, 1'b1);
        idle();

        // SKID_EN=0 with out_ready toggling 1,0,1.
        for (int i = 0; i < 9; i++) step(1'b1, 64'(16'h5000 + i), 16'(16'h0500 + i), (i % 3) != 1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

        // Reset mid-operation with d0 holding two entries.
        step(1'b1, 64'h61, 16'h0061, 1'b0, 1'b0);
        step(1'b1, 64'h62, 16'h0062, 1'b0, 1'b0);
        pulse_reset();
        idle();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 16'($urandom_range(0, 65535)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 16'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
